// File: rtl/dcache_dm_pkg.sv
// Shared geometry constants, controller states and request-buffer layout
// for the direct-mapped data cache.
package dcache_dm_pkg;
    localparam int TAG_W      = 20;
    localparam int INDEX_W    = 8;
    localparam int OFFSET_W   = 4;
    localparam int LINE_WORDS = 4;
    localparam int LINES      = 256;
    localparam int LINE_W     = 32 * LINE_WORDS;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOOKUP  = 3'd1,
        S_MISS    = 3'd2,
        S_REPLACE = 3'd3,
        S_REFILL  = 3'd4
    } state_t;

    typedef struct packed {
        logic                op;
        logic [TAG_W-1:0]    tag;
        logic [INDEX_W-1:0]  index;
        logic [OFFSET_W-1:0] offset;
        logic [3:0]          wstrb;
        logic [31:0]         wdata;
    } req_t;
endpackage

// File: rtl/dcache_way_ram.sv
// Line storage: valid/dirty/tag/data arrays with a combinational read port,
// a byte-strobed word write port and a full-line (refill) write port.
module dcache_way_ram
    import dcache_dm_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [INDEX_W-1:0] rd_index,
    output logic               rd_valid,
    output logic               rd_dirty,
    output logic [TAG_W-1:0]   rd_tag,
    output logic [LINE_W-1:0]  rd_line,
    input  logic               word_we,
    input  logic [INDEX_W-1:0] word_index,
    input  logic [1:0]         word_sel,
    input  logic [3:0]         word_wstrb,
    input  logic [31:0]        word_wdata,
    input  logic               line_we,
    input  logic [INDEX_W-1:0] line_index,
    input  logic [TAG_W-1:0]   line_tag,
    input  logic [LINE_W-1:0]  line_data
);
    logic [LINES-1:0]  valid_q;
    logic [LINES-1:0]  dirty_q;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [LINE_W-1:0] data_q [LINES];

    assign rd_valid = valid_q[rd_index];
    assign rd_dirty = dirty_q[rd_index];
    assign rd_tag   = tag_q[rd_index];
    assign rd_line  = data_q[rd_index];

    // A zero-strobe store leaves the dirty bit alone.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (line_we) begin
            valid_q[line_index] <= 1'b1;
            dirty_q[line_index] <= 1'b0;
        end else if (word_we && (|word_wstrb)) begin
            dirty_q[word_index] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (line_we) begin
            tag_q[line_index]  <= line_tag;
            data_q[line_index] <= line_data;
        end else if (word_we) begin
            for (int b = 0; b < 4; b++) begin
                if (word_wstrb[b])
                    data_q[word_index][32*word_sel + 8*b +: 8] <= word_wdata[8*b +: 8];
            end
        end
    end
endmodule

// File: rtl/dcache_dm.sv
// Direct-mapped write-back / write-allocate data cache controller: request
// buffer, lookup, dirty write-back, burst refill and re-lookup.
module dcache_dm
    import dcache_dm_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                data_valid,
    input  logic                data_op,
    input  logic [TAG_W-1:0]    data_tag,
    input  logic [INDEX_W-1:0]  data_index,
    input  logic [OFFSET_W-1:0] data_offset,
    input  logic [3:0]          data_wstrb,
    input  logic [31:0]         data_wdata,
    output logic                data_addr_ok,
    output logic                data_data_ok,
    output logic [31:0]         data_rdata,
    output logic                rd_req,
    output logic [31:0]         rd_addr,
    input  logic                rd_rdy,
    input  logic                ret_valid,
    input  logic                ret_last,
    input  logic [31:0]         ret_data,
    output logic                wr_req,
    output logic [31:0]         wr_addr,
    output logic [LINE_W-1:0]   wr_data,
    input  logic                wr_rdy
);
    state_t             state_q, state_d;
    req_t               req_q;
    logic [1:0]         cnt_q;
    logic [LINE_W-1:0]  fill_q, fill_line;
    logic [31:0]        rdata_q, sel_word;
    logic               rd_valid, rd_dirty, hit;
    logic [TAG_W-1:0]   rd_tag;
    logic [LINE_W-1:0]  rd_line;
    logic               word_we, line_we;
    logic [1:0]         wsel;
    logic               unused_offset;

    assign wsel          = req_q.offset[3:2];
    assign unused_offset = ^req_q.offset[1:0];

    dcache_way_ram u_ram (
        .clk        (clk),
        .reset      (reset),
        .rd_index   (req_q.index),
        .rd_valid   (rd_valid),
        .rd_dirty   (rd_dirty),
        .rd_tag     (rd_tag),
        .rd_line    (rd_line),
        .word_we    (word_we),
        .word_index (req_q.index),
        .word_sel   (wsel),
        .word_wstrb (req_q.wstrb),
        .word_wdata (req_q.wdata),
        .line_we    (line_we),
        .line_index (req_q.index),
        .line_tag   (req_q.tag),
        .line_data  (fill_line)
    );

    assign hit      = rd_valid && (rd_tag == req_q.tag);
    assign sel_word = rd_line[32*wsel +: 32];

    // Incoming beat lands in the assembled line so the last beat can be
    // written together with the rest in one line write.
    always_comb begin
        fill_line = fill_q;
        fill_line[32*cnt_q +: 32] = ret_data;
    end

    always_comb begin
        state_d      = state_q;
        data_data_ok = 1'b0;
        wr_req       = 1'b0;
        rd_req       = 1'b0;
        word_we      = 1'b0;
        line_we      = 1'b0;
        case (state_q)
            S_IDLE:    if (data_valid) state_d = S_LOOKUP;
            S_LOOKUP: begin
                if (hit) begin
                    data_data_ok = 1'b1;
                    word_we      = req_q.op;
                    state_d      = S_IDLE;
                end else if (rd_valid && rd_dirty) begin
                    state_d = S_MISS;
                end else begin
                    state_d = S_REPLACE;
                end
            end
            S_MISS: begin
                wr_req = 1'b1;
                if (wr_rdy) state_d = S_REPLACE;
            end
            S_REPLACE: begin
                rd_req = 1'b1;
                if (rd_rdy) state_d = S_REFILL;
            end
            S_REFILL: begin
                if (ret_valid && ret_last) begin
                    line_we = 1'b1;
                    state_d = S_LOOKUP;
                end
            end
            default:   state_d = S_IDLE;
        endcase
    end

    assign data_addr_ok = (state_q == S_IDLE);
    assign data_rdata   = data_data_ok ? sel_word : rdata_q;
    assign wr_addr      = wr_req ? {rd_tag, req_q.index, 4'b0} : 32'd0;
    assign wr_data      = wr_req ? rd_line : '0;
    assign rd_addr      = rd_req ? {req_q.tag, req_q.index, 4'b0} : 32'd0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            req_q   <= '0;
            cnt_q   <= 2'd0;
            fill_q  <= '0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && data_valid) begin
                req_q.op     <= data_op;
                req_q.tag    <= data_tag;
                req_q.index  <= data_index;
                req_q.offset <= data_offset;
                req_q.wstrb  <= data_wstrb;
                req_q.wdata  <= data_wdata;
            end
            if (data_data_ok) rdata_q <= sel_word;
            if (state_q == S_REFILL && ret_valid) begin
                fill_q <= fill_line;
                cnt_q  <= ret_last ? 2'd0 : cnt_q + 2'd1;
            end
        end
    end
endmodule

// File: tb/tb_dcache_dm.sv
// Directed bench for dcache_dm: a line-level cache/memory model predicts
// hit/miss, write-back and refill traffic; a per-cycle loop checks the DUT.
module tb_dcache_dm;
    logic         clk = 1'b0;
    logic         reset;
    logic         data_valid, data_op;
    logic [19:0]  data_tag;
    logic [7:0]   data_index;
    logic [3:0]   data_offset, data_wstrb;
    logic [31:0]  data_wdata;
    logic         data_addr_ok, data_data_ok;
    logic [31:0]  data_rdata;
    logic         rd_req, rd_rdy, ret_valid, ret_last;
    logic [31:0]  rd_addr, ret_data;
    logic         wr_req, wr_rdy;
    logic [31:0]  wr_addr;
    logic [127:0] wr_data;

    int checks = 0;
    int errors = 0;

    dcache_dm dut (
        .clk(clk), .reset(reset),
        .data_valid(data_valid), .data_op(data_op), .data_tag(data_tag),
        .data_index(data_index), .data_offset(data_offset), .data_wstrb(data_wstrb),
        .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .data_rdata(data_rdata), .rd_req(rd_req), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
        .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_rdy(wr_rdy)
    );

    always #5 clk = ~clk;

    // Model: cache contents per index, backing memory as a sparse word map.
    bit          m_valid [256];
    bit          m_dirty [256];
    logic [19:0] m_tag   [256];
    logic [31:0] m_line  [256][4];
    logic [31:0] mem [int unsigned];

    function automatic logic [31:0] memword(logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return 32'hA000_0000 | a;
    endfunction

    task automatic chk(string name, logic [127:0] got, logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic chk_reset();
        chk("rst_addr_ok", data_addr_ok, 1);
        chk("rst_data_ok", data_data_ok, 0);
        chk("rst_rdata",   data_rdata, 0);
        chk("rst_rd_req",  rd_req, 0);
        chk("rst_wr_req",  wr_req, 0);
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        for (int i = 0; i < 256; i++) begin
            m_valid[i] = 0;
            m_dirty[i] = 0;
        end
    endtask

    task automatic req(input bit op, input logic [31:0] addr, input logic [3:0] wstrb,
                       input logic [31:0] wdata, input int wstall, input int abort_beats,
                       output logic [31:0] o_rdata, output int o_lat,
                       output logic [31:0] o_wr_addr, output logic [127:0] o_wr_data,
                       output logic [31:0] o_rd_addr, output int o_wr_cyc, output int o_rd_cyc);
        logic [7:0]   idx;
        logic [19:0]  tg;
        logic [1:0]   w;
        bit           exp_hit, exp_wb, wb_acc, rd_acc, done;
        logic [31:0]  exp_wb_addr, exp_rd_addr, exp_rdata;
        logic [127:0] exp_wb_data;
        logic [31:0]  nl [4];
        int           beat;
        idx = addr[11:4];
        tg  = addr[31:12];
        w   = addr[3:2];
        exp_hit     = m_valid[idx] && (m_tag[idx] == tg);
        exp_wb      = !exp_hit && m_valid[idx] && m_dirty[idx];
        exp_wb_addr = {m_tag[idx], idx, 4'b0};
        exp_wb_data = {m_line[idx][3], m_line[idx][2], m_line[idx][1], m_line[idx][0]};
        exp_rd_addr = {tg, idx, 4'b0};
        for (int k = 0; k < 4; k++)
            nl[k] = exp_hit ? m_line[idx][k] : memword(exp_rd_addr + 32'(4*k));
        exp_rdata = nl[w];
        o_rdata = 0; o_lat = -1; o_wr_addr = 0; o_wr_data = 0; o_rd_addr = 0;
        o_wr_cyc = 0; o_rd_cyc = 0;
        wb_acc = 0; rd_acc = 0; done = 0; beat = 0;

        @(negedge clk);
        chk("addr_ok_idle", data_addr_ok, 1);
        data_valid = 1; data_op = op; data_tag = tg; data_index = idx;
        data_offset = addr[3:0]; data_wstrb = wstrb; data_wdata = wdata;
        @(negedge clk);
        data_valid = 0;
        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            ret_valid = 0; ret_last = 0; wr_rdy = 0; rd_rdy = 0;
            chk("addr_ok_busy", data_addr_ok, 0);
            if (wr_req) begin
                chk("wr_req_expected", exp_wb, 1);
                chk("wr_addr", wr_addr, exp_wb_addr);
                chk("wr_data", wr_data, exp_wb_data);
                o_wr_cyc++;
                o_wr_addr = wr_addr;
                o_wr_data = wr_data;
                if (o_wr_cyc > wstall) begin
                    wr_rdy = 1;
                    wb_acc = 1;
                end
            end
            if (rd_req) begin
                chk("rd_req_expected", exp_hit, 0);
                chk("wb_before_rd", wb_acc, exp_wb);
                chk("rd_addr", rd_addr, exp_rd_addr);
                o_rd_cyc++;
                o_rd_addr = rd_addr;
                rd_rdy = 1;
                rd_acc = 1;
            end else if (rd_acc && beat < 4) begin
                if (beat == abort_beats) begin
                    reset = 1;
                    @(negedge clk);
                    reset = 0;
                    chk_reset();
                    return;
                end
                ret_valid = 1;
                ret_data  = memword(exp_rd_addr + 32'(4*beat));
                ret_last  = (beat == 3);
                beat++;
            end
            if (data_data_ok) begin
                done    = 1;
                o_lat   = cyc;
                o_rdata = data_rdata;
                if (!op) chk("load_rdata", data_rdata, exp_rdata);
                if (!exp_hit) chk("refill_before_ok", beat, 4);
            end
            if (!done) @(negedge clk);
        end
        ret_valid = 0; ret_last = 0; wr_rdy = 0; rd_rdy = 0;
        chk("completed", done, 1);
        chk("wr_cycles", o_wr_cyc, exp_wb ? wstall + 1 : 0);
        chk("rd_cycles", o_rd_cyc, exp_hit ? 0 : 1);
        @(negedge clk);
        chk("addr_ok_after", data_addr_ok, 1);
        chk("data_ok_pulse", data_data_ok, 0);
        chk("rdata_hold", data_rdata, o_rdata);

        if (exp_wb)
            for (int k = 0; k < 4; k++) mem[exp_wb_addr + 32'(4*k)] = m_line[idx][k];
        if (!exp_hit) begin
            for (int k = 0; k < 4; k++) m_line[idx][k] = nl[k];
            m_valid[idx] = 1;
            m_dirty[idx] = 0;
            m_tag[idx]   = tg;
        end
        if (op) begin
            for (int b = 0; b < 4; b++)
                if (wstrb[b]) m_line[idx][w][8*b +: 8] = wdata[8*b +: 8];
            if (|wstrb) m_dirty[idx] = 1;
        end
    endtask

    logic [31:0]  r, wa, ra;
    logic [127:0] wd;
    int           lat, wc, rc;

    initial begin
        reset = 1; data_valid = 0; data_op = 0; data_tag = 0; data_index = 0;
        data_offset = 0; data_wstrb = 0; data_wdata = 0;
        rd_rdy = 0; ret_valid = 0; ret_last = 0; ret_data = 0; wr_rdy = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset();
        reset = 0;

        req(0, 32'h0000_1004, 4'h0, 0, 0, -1, r, lat, wa, wd, ra, wc, rc);
        chk("t1_rdata", r, 32'hA000_1004);
        chk("t1_rd_addr", ra, 32'h0000_1000);
        chk("t1_no_wr", wc, 0);

        req(0, 32'h0000_1008, 4'h0, 0, 0, -1, r, lat, wa, wd, ra, wc, rc);
        chk("hit_rdata", r, 32'hA000_1008);
        chk("hit_latency", lat, 0);
        chk("hit_no_rd", rc, 0);

        req(1, 32'h0000_1000, 4'b0011, 32'hBEEF_CAFE, 0, -1, r, lat, wa, wd, ra, wc, rc);
        chk("store_hit_latency", lat, 0);
        req(0, 32'h0000_1000, 4'h0, 0, 0, -1, r, lat, wa, wd, ra, wc, rc);
        chk("merge_rdata", r, 32'hA000_CAFE);

        req(0, 32'h0010_1000, 4'h0, 0, 5, -1, r, lat, wa, wd, ra, wc, rc);
        chk("evict_wr_addr", wa, 32'h0000_1000);
        chk("evict_wr_data", wd, {32'hA000_100C, 32'hA000_1008, 32'hA000_1004, 32'hA000_CAFE});
        chk("evict_wr_cycles", wc, 6);
        chk("evict_rd_addr", ra, 32'h0010_1000);
        chk("evict_rdata", r, 32'hA010_1000);

        req(0, 32'h0000_1000, 4'h0, 0, 0, -1, r, lat, wa, wd, ra, wc, rc);
        chk("wb_mem_rdata", r, 32'hA000_CAFE);
        chk("clean_no_wr", wc, 0);

        req(1, 32'h0000_4008, 4'b1100, 32'h1234_5678, 0, -1, r, lat, wa, wd, ra, wc, rc);
        chk("store_miss_rd", rc, 1);
        req(0, 32'h0000_4008, 4'h0, 0, 0, -1, r, lat, wa, wd, ra, wc, rc);
        chk("store_alloc_rdata", r, 32'h1234_4008);

        req(0, 32'h0000_2020, 4'h0, 0, 0, -1, r, lat, wa, wd, ra, wc, rc);
        req(1, 32'h0000_2020, 4'h0, 32'hFFFF_FFFF, 0, -1, r, lat, wa, wd, ra, wc, rc);
        req(0, 32'h0000_5020, 4'h0, 0, 0, -1, r, lat, wa, wd, ra, wc, rc);
        chk("zero_strobe_clean", wc, 0);
        chk("zero_strobe_rdata", r, 32'hA000_5020);

        @(negedge clk);
        ret_valid = 1; ret_last = 1; ret_data = 32'hDEAD_BEEF;
        @(negedge clk);
        ret_valid = 0; ret_last = 0;
        req(0, 32'h0000_4008, 4'h0, 0, 0, -1, r, lat, wa, wd, ra, wc, rc);
        chk("stray_ret_hit", lat, 0);
        chk("stray_ret_rdata", r, 32'h1234_4008);

        req(0, 32'h0000_3010, 4'h0, 0, 0, 2, r, lat, wa, wd, ra, wc, rc);
        req(0, 32'h0000_3010, 4'h0, 0, 0, -1, r, lat, wa, wd, ra, wc, rc);
        chk("post_reset_miss", rc, 1);
        chk("post_reset_rdata", r, 32'hA000_3010);
        req(0, 32'h0000_4008, 4'h0, 0, 0, -1, r, lat, wa, wd, ra, wc, rc);
        chk("post_reset_no_wb", wc, 0);
        chk("post_reset_rdata2", r, 32'hA000_4008);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end
endmodule
